digger_mover: RTL and testbench

Parametrised tile-map player controller for the Digger game. It sits between the key decoder and port A of the VGA tile RAM. After reset it scans the RAM to locate the digger tile. It then executes one grid move per key press: it reads the target cell, digs dirt, respects edges and blocking tiles, and rewrites the RAM (new cell, old cell, facing). Successor to the fixed 150-cell prototype, with configurable grid size and tile width, a real read/write sequence, bounds checks and a rescan mode.

---
 rtl/digger_pkg.sv | 25 ++
 rtl/digger_target_calc.sv | 66 ++++++
 rtl/digger_mover.sv | 148 ++++++++++++++
 tb/tb_digger_mover.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digger_pkg.sv
// Shared tile codes, key codes and controller state encoding for the digger tile-map mover.
package digger_pkg;

  localparam int TILE_TUNNEL = 0;
  localparam int TILE_UP     = 1;
  localparam int TILE_DOWN   = 2;
  localparam int TILE_LEFT   = 3;
  localparam int TILE_RIGHT  = 4;
  localparam int TILE_DIRT   = 5;

  localparam logic [2:0] KEY_NONE  = 3'b000;
  localparam logic [2:0] KEY_UP    = 3'b001;
  localparam logic [2:0] KEY_DOWN  = 3'b010;
  localparam logic [2:0] KEY_LEFT  = 3'b011;
  localparam logic [2:0] KEY_RIGHT = 3'b100;

  typedef enum logic [2:0] {
    SCAN, IDLE, RD, EVAL, WR_NEW, WR_OLD, WR_TURN, WAIT_REL
  } state_t;

  function automatic logic key_valid(input logic [2:0] k);
    return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
  endfunction

endpackage

// File: rtl/digger_target_calc.sv
// Combinational move target: neighbour cell of the digger, grid-edge check and facing tile code.
module digger_target_calc
  import digger_pkg::*;
#(
  parameter int COLS   = 15,
  parameter int ROWS   = 10,
  parameter int TILE_W = 4,
  parameter int ADDR_W = 8,
  parameter int RW     = 4,
  parameter int CW     = 4
) (
  input  logic [RW-1:0]     pos_row,
  input  logic [CW-1:0]     pos_col,
  input  logic [ADDR_W-1:0] pos_addr,
  input  logic [2:0]        key,
  output logic [RW-1:0]     tgt_row,
  output logic [CW-1:0]     tgt_col,
  output logic [ADDR_W-1:0] tgt_addr,
  output logic              edge_block,
  output logic [TILE_W-1:0] facing
);

  always_comb begin
    tgt_row    = pos_row;
    tgt_col    = pos_col;
    tgt_addr   = pos_addr;
    edge_block = 1'b0;
    facing     = TILE_W'(TILE_TUNNEL);
    case (key)
      KEY_UP: begin
        facing = TILE_W'(TILE_UP);
        if (pos_row == '0) edge_block = 1'b1;
        else begin
          tgt_row  = pos_row - RW'(1);
          tgt_addr = pos_addr - ADDR_W'(COLS);
        end
      end
      KEY_DOWN: begin
        facing = TILE_W'(TILE_DOWN);
        if (pos_row == RW'(ROWS - 1)) edge_block = 1'b1;
        else begin
          tgt_row  = pos_row + RW'(1);
          tgt_addr = pos_addr + ADDR_W'(COLS);
        end
      end
      KEY_LEFT: begin
        facing = TILE_W'(TILE_LEFT);
        if (pos_col == '0) edge_block = 1'b1;
        else begin
          tgt_col  = pos_col - CW'(1);
          tgt_addr = pos_addr - ADDR_W'(1);
        end
      end
      KEY_RIGHT: begin
        facing = TILE_W'(TILE_RIGHT);
        if (pos_col == CW'(COLS - 1)) edge_block = 1'b1;
        else begin
          tgt_col  = pos_col + CW'(1);
          tgt_addr = pos_addr + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/digger_mover.sv
// Digger player controller: scans tile RAM for the digger, then performs one read/evaluate/write
// grid move per key press, driving RAM port A with registered outputs.
module digger_mover
  import digger_pkg::*;
#(
  parameter int COLS   = 15,
  parameter int ROWS   = 10,
  parameter int TILE_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     test_clk,
  input  logic                     rst,
  input  logic [2:0]               key,
  input  logic                     rescan,
  input  logic [TILE_W-1:0]        vgaram_douta,
  output logic                     vgaram_we,
  output logic [ADDR_W-1:0]        vgaram_addra,
  output logic [TILE_W-1:0]        vgaram_dina,
  output logic                     found,
  output logic [$clog2(ROWS)-1:0]  pos_row,
  output logic [$clog2(COLS)-1:0]  pos_col,
  output logic                     busy,
  output logic                     dug
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);

  state_t state, state_n;
  logic              we_n, found_n, dug_n, dirt, dirt_n, sc_done, sc_done_n;
  logic              vld_p0, vld_p0_n, vld_p1, vld_p1_n;
  logic [ADDR_W-1:0] addra_n, pos_addr, pos_addr_n, sc_addr, sc_addr_n;
  logic [TILE_W-1:0] dina_n;
  logic [RW-1:0]     pos_row_n, sc_row, sc_row_n;
  logic [CW-1:0]     pos_col_n, sc_col, sc_col_n;
  logic [2:0]        mv_key, mv_key_n, calc_key;
  logic [RW-1:0]     scan_row_p0, scan_row_p1, tgt_row;
  logic [CW-1:0]     scan_col_p0, scan_col_p1, tgt_col;
  logic [ADDR_W-1:0] scan_addr_p0, scan_addr_p1, tgt_addr;
  logic              edge_block;
  logic [TILE_W-1:0] facing;

  function automatic logic is_digger(input logic [TILE_W-1:0] c);
    return (c >= TILE_W'(TILE_UP)) && (c <= TILE_W'(TILE_RIGHT));
  endfunction

  // The key is only live in IDLE; later move states work from the latched press.
  assign calc_key = (state == IDLE) ? key : mv_key;
  assign busy     = (state != IDLE);

  digger_target_calc #(
    .COLS(COLS), .ROWS(ROWS), .TILE_W(TILE_W), .ADDR_W(ADDR_W), .RW(RW), .CW(CW)
  ) u_target (
    .pos_row(pos_row), .pos_col(pos_col), .pos_addr(pos_addr), .key(calc_key),
    .tgt_row(tgt_row), .tgt_col(tgt_col), .tgt_addr(tgt_addr),
    .edge_block(edge_block), .facing(facing)
  );

  always_comb begin
    state_n = state;     we_n = 1'b0;          addra_n = vgaram_addra;
    dina_n = vgaram_dina; found_n = found;      dug_n = 1'b0;
    pos_row_n = pos_row; pos_col_n = pos_col;   pos_addr_n = pos_addr;
    mv_key_n = mv_key;   dirt_n = dirt;
    sc_row_n = sc_row;   sc_col_n = sc_col;     sc_addr_n = sc_addr;  sc_done_n = sc_done;
    vld_p0_n = 1'b0;     vld_p1_n = 1'b0;
    case (state)
      SCAN: begin
        vld_p1_n = vld_p0;
        if (!sc_done) begin
          addra_n   = sc_addr;
          vld_p0_n  = 1'b1;
          sc_done_n = (sc_addr == LAST);
          sc_addr_n = sc_addr + ADDR_W'(1);
          if (sc_col == CW'(COLS - 1)) begin
            sc_col_n = '0;
            sc_row_n = sc_row + RW'(1);
          end else sc_col_n = sc_col + CW'(1);
        end
        if (vld_p1 && is_digger(vgaram_douta)) begin
          state_n = IDLE;  found_n = 1'b1;
          pos_row_n = scan_row_p1;  pos_col_n = scan_col_p1;  pos_addr_n = scan_addr_p1;
        end else if (vld_p1 && (scan_addr_p1 == LAST)) state_n = IDLE;
      end
      IDLE: begin
        if (rescan) begin
          state_n = SCAN;  found_n = 1'b0;
          sc_row_n = '0;  sc_col_n = '0;  sc_addr_n = '0;  sc_done_n = 1'b0;
        end else if (found && key_valid(key)) begin
          mv_key_n = key;
          dirt_n   = 1'b0;
          if (edge_block) begin
            state_n = WR_TURN;  we_n = 1'b1;  addra_n = pos_addr;  dina_n = facing;
          end else begin
            state_n = RD;  addra_n = tgt_addr;
          end
        end
      end
      RD: state_n = EVAL;
      EVAL: begin
        we_n   = 1'b1;
        dina_n = facing;
        if ((vgaram_douta == TILE_W'(TILE_TUNNEL)) || (vgaram_douta == TILE_W'(TILE_DIRT))) begin
          state_n = WR_NEW;  addra_n = tgt_addr;
          dirt_n  = (vgaram_douta == TILE_W'(TILE_DIRT));
        end else begin
          state_n = WR_TURN;  addra_n = pos_addr;
        end
      end
      WR_NEW: begin
        state_n = WR_OLD;  we_n = 1'b1;  addra_n = pos_addr;  dina_n = '0;
        pos_row_n = tgt_row;  pos_col_n = tgt_col;  pos_addr_n = tgt_addr;  dug_n = dirt;
      end
      WR_OLD, WR_TURN: state_n = WAIT_REL;
      WAIT_REL: if (key == KEY_NONE) state_n = IDLE;
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge test_clk) begin
    if (rst) begin
      state <= SCAN;  vgaram_we <= 1'b0;  vgaram_addra <= '0;  vgaram_dina <= '0;
      found <= 1'b0;  dug <= 1'b0;  pos_row <= '0;  pos_col <= '0;  pos_addr <= '0;
      mv_key <= KEY_NONE;  dirt <= 1'b0;
      sc_row <= '0;  sc_col <= '0;  sc_addr <= '0;  sc_done <= 1'b0;
      vld_p0 <= 1'b0;  vld_p1 <= 1'b0;
    end else begin
      state <= state_n;  vgaram_we <= we_n;  vgaram_addra <= addra_n;  vgaram_dina <= dina_n;
      found <= found_n;  dug <= dug_n;  pos_row <= pos_row_n;  pos_col <= pos_col_n;
      pos_addr <= pos_addr_n;  mv_key <= mv_key_n;  dirt <= dirt_n;
      sc_row <= sc_row_n;  sc_col <= sc_col_n;  sc_addr <= sc_addr_n;  sc_done <= sc_done_n;
      vld_p0 <= vld_p0_n;  vld_p1 <= vld_p1_n;
    end
  end

  // p0: cell whose address is on the RAM port; p1: cell whose data is on douta.
  always_ff @(posedge test_clk) begin
    if ((state == SCAN) && !sc_done) begin
      scan_row_p0  <= sc_row;
      scan_col_p0  <= sc_col;
      scan_addr_p0 <= sc_addr;
    end
    scan_row_p1  <= scan_row_p0;
    scan_col_p1  <= scan_col_p0;
    scan_addr_p1 <= scan_addr_p0;
  end

endmodule

// File: tb/tb_digger_mover.sv
// Directed bench for digger_mover on a 15x10 grid with a behavioural synchronous tile RAM.
module tb_digger_mover;

  logic       test_clk = 1'b0;
  logic       rst = 1'b1, rescan = 1'b0, tb_we = 1'b0;
  logic [2:0] key = 3'b000;
  logic [3:0] douta, dina, tb_data;
  logic [7:0] addra, tb_addr;
  logic       we, found, busy, dug;
  logic [3:0] pos_row, pos_col;
  logic [3:0] mem [0:255];
  int wr_count = 0, dug_count = 0, total = 0, bad = 0;

  always #5 test_clk = ~test_clk;

  digger_mover #(.COLS(15), .ROWS(10), .TILE_W(4), .ADDR_W(8)) dut (
    .test_clk(test_clk), .rst(rst), .key(key), .rescan(rescan), .vgaram_douta(douta),
    .vgaram_we(we), .vgaram_addra(addra), .vgaram_dina(dina), .found(found),
    .pos_row(pos_row), .pos_col(pos_col), .busy(busy), .dug(dug)
  );

  always @(posedge test_clk) begin
    douta <= mem[addra];
    if (we) begin
      mem[addra] <= dina;
      wr_count   <= wr_count + 1;
    end else if (tb_we) mem[tb_addr] <= tb_data;
    if (dug) dug_count <= dug_count + 1;
  end

  task automatic fill_dirt();
    @(negedge test_clk);
    tb_we = 1'b1;
    for (int a = 0; a < 150; a++) begin
      tb_addr = 8'(a);  tb_data = 4'd5;
      @(negedge test_clk);
    end
    tb_we = 1'b0;
  endtask

  task automatic poke(input int a, input int d);
    @(negedge test_clk);
    tb_we = 1'b1;  tb_addr = 8'(a);  tb_data = 4'(d);
    @(negedge test_clk);
    tb_we = 1'b0;
  endtask

  task automatic load_and_scan(input int a1, input int c1, input int a2, input int c2);
    @(negedge test_clk);
    rst = 1'b1;  key = 3'b000;  rescan = 1'b0;
    fill_dirt();
    poke(a1, c1);
    if (a2 >= 0) poke(a2, c2);
    @(negedge test_clk);
    rst = 1'b0;
    repeat (160) @(negedge test_clk);
  endtask

  task automatic test_reset();
    @(negedge test_clk);
    rst = 1'b1;  key = 3'b000;  rescan = 1'b0;
    fill_dirt();
    poke(37, 4);
    @(negedge test_clk);
    total++; if (we !== 1'b0)     begin bad++; $display("FAIL reset_we got %0d want 0", we); end
    total++; if (addra !== 8'd0)  begin bad++; $display("FAIL reset_addra got %0d want 0", addra); end
    total++; if (dina !== 4'd0)   begin bad++; $display("FAIL reset_dina got %0d want 0", dina); end
    total++; if (found !== 1'b0)  begin bad++; $display("FAIL reset_found got %0d want 0", found); end
    total++; if (pos_row !== 4'd0 || pos_col !== 4'd0)
      begin bad++; $display("FAIL reset_pos got (%0d,%0d) want (0,0)", pos_row, pos_col); end
    total++; if (busy !== 1'b1)   begin bad++; $display("FAIL reset_busy got %0d want 1", busy); end
    total++; if (dug !== 1'b0)    begin bad++; $display("FAIL reset_dug got %0d want 0", dug); end
  endtask

  task automatic test_scan();
    int w0;
    w0 = wr_count;
    @(negedge test_clk);
    rst = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge test_clk);
      if (c == 38) begin
        total++; if (addra !== 8'd37) begin bad++; $display("FAIL scan_addr38 got %0d want 37", addra); end
      end
      if (c == 39) begin
        total++; if (found !== 1'b0) begin bad++; $display("FAIL scan_found39 got %0d want 0", found); end
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL scan_found40 got %0d want 1", found); end
    total++; if (pos_row !== 4'd2 || pos_col !== 4'd7)
      begin bad++; $display("FAIL scan_pos got (%0d,%0d) want (2,7)", pos_row, pos_col); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_idle_busy got %0d want 0", busy); end
    total++; if (wr_count - w0 != 0) begin bad++; $display("FAIL scan_writes got %0d want 0", wr_count - w0); end
  endtask

  task automatic test_move_dig();
    int w0, d0;
    w0 = wr_count;  d0 = dug_count;
    @(negedge test_clk);  key = 3'b100;
    @(negedge test_clk);
    total++; if (addra !== 8'd38 || we !== 1'b0)
      begin bad++; $display("FAIL dig_rd got addr=%0d we=%0d want addr=38 we=0", addra, we); end
    @(negedge test_clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL dig_eval_we got %0d want 0", we); end
    @(negedge test_clk);
    total++; if (we !== 1'b1 || addra !== 8'd38 || dina !== 4'd4)
      begin bad++; $display("FAIL dig_wr_new got we=%0d addr=%0d data=%0d want 1/38/4", we, addra, dina); end
    @(negedge test_clk);
    total++; if (we !== 1'b1 || addra !== 8'd37 || dina !== 4'd0)
      begin bad++; $display("FAIL dig_wr_old got we=%0d addr=%0d data=%0d want 1/37/0", we, addra, dina); end
    total++; if (dug !== 1'b1) begin bad++; $display("FAIL dig_dug got %0d want 1", dug); end
    total++; if (pos_row !== 4'd2 || pos_col !== 4'd8)
      begin bad++; $display("FAIL dig_pos got (%0d,%0d) want (2,8)", pos_row, pos_col); end
    @(negedge test_clk);
    total++; if (we !== 1'b0 || dug !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL dig_wait got we=%0d dug=%0d busy=%0d want 0/0/1", we, dug, busy); end
    key = 3'b000;
    repeat (3) @(negedge test_clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dig_release_busy got %0d want 0", busy); end
    total++; if (mem[38] !== 4'd4 || mem[37] !== 4'd0)
      begin bad++; $display("FAIL dig_ram got m38=%0d m37=%0d want 4/0", mem[38], mem[37]); end
    total++; if (wr_count - w0 != 2 || dug_count - d0 != 1)
      begin bad++; $display("FAIL dig_counts got wr=%0d dug=%0d want 2/1", wr_count - w0, dug_count - d0); end
  endtask

  task automatic test_edge_block();
    int w0, d0;
    load_and_scan(3, 1, -1, 0);
    total++; if (found !== 1'b1 || pos_row !== 4'd0 || pos_col !== 4'd3)
      begin bad++; $display("FAIL edge_scan got f=%0d (%0d,%0d) want 1 (0,3)", found, pos_row, pos_col); end
    w0 = wr_count;  d0 = dug_count;
    @(negedge test_clk);  key = 3'b001;
    @(negedge test_clk);
    total++; if (we !== 1'b1 || addra !== 8'd3 || dina !== 4'd1)
      begin bad++; $display("FAIL edge_turn got we=%0d addr=%0d data=%0d want 1/3/1", we, addra, dina); end
    @(negedge test_clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL edge_we_once got %0d want 0", we); end
    key = 3'b000;
    repeat (3) @(negedge test_clk);
    total++; if (pos_row !== 4'd0 || pos_col !== 4'd3)
      begin bad++; $display("FAIL edge_pos got (%0d,%0d) want (0,3)", pos_row, pos_col); end
    total++; if (wr_count - w0 != 1 || dug_count - d0 != 0)
      begin bad++; $display("FAIL edge_counts got wr=%0d dug=%0d want 1/0", wr_count - w0, dug_count - d0); end
  endtask

  task automatic test_tile_block();
    int w0;
    load_and_scan(37, 4, 52, 6);
    w0 = wr_count;
    @(negedge test_clk);  key = 3'b010;
    @(negedge test_clk);
    total++; if (addra !== 8'd52 || we !== 1'b0)
      begin bad++; $display("FAIL tile_rd got addr=%0d we=%0d want 52/0", addra, we); end
    @(negedge test_clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL tile_eval_we got %0d want 0", we); end
    @(negedge test_clk);
    total++; if (we !== 1'b1 || addra !== 8'd37 || dina !== 4'd2)
      begin bad++; $display("FAIL tile_turn got we=%0d addr=%0d data=%0d want 1/37/2", we, addra, dina); end
    @(negedge test_clk);
    total++; if (we !== 1'b0) begin bad++; $display("FAIL tile_we_once got %0d want 0", we); end
    key = 3'b000;
    repeat (3) @(negedge test_clk);
    total++; if (pos_row !== 4'd2 || pos_col !== 4'd7)
      begin bad++; $display("FAIL tile_pos got (%0d,%0d) want (2,7)", pos_row, pos_col); end
    total++; if (wr_count - w0 != 1 || mem[37] !== 4'd2 || mem[52] !== 4'd6)
      begin bad++; $display("FAIL tile_ram got wr=%0d m37=%0d m52=%0d want 1/2/6", wr_count - w0, mem[37], mem[52]); end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    load_and_scan(37, 4, -1, 0);
    w0 = wr_count;  d0 = dug_count;
    @(negedge test_clk);  key = 3'b100;
    repeat (20) @(negedge test_clk);
    total++; if (wr_count - w0 != 2 || pos_col !== 4'd8)
      begin bad++; $display("FAIL hold_one_move got wr=%0d col=%0d want 2/8", wr_count - w0, pos_col); end
    key = 3'b000;
    @(negedge test_clk);  key = 3'b100;
    repeat (10) @(negedge test_clk);
    key = 3'b000;
    repeat (3) @(negedge test_clk);
    total++; if (pos_row !== 4'd2 || pos_col !== 4'd9)
      begin bad++; $display("FAIL second_move_pos got (%0d,%0d) want (2,9)", pos_row, pos_col); end
    total++; if (wr_count - w0 != 4 || dug_count - d0 != 2)
      begin bad++; $display("FAIL second_move_counts got wr=%0d dug=%0d want 4/2", wr_count - w0, dug_count - d0); end
    total++; if (mem[39] !== 4'd4 || mem[38] !== 4'd0)
      begin bad++; $display("FAIL second_move_ram got m39=%0d m38=%0d want 4/0", mem[39], mem[38]); end
  endtask

  task automatic test_rescan();
    int w0;
    @(negedge test_clk);
    rst = 1'b1;  key = 3'b000;
    fill_dirt();
    @(negedge test_clk);
    rst = 1'b0;
    for (int c = 1; c <= 152; c++) begin
      @(negedge test_clk);
      if (c == 151) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL noscan_busy151 got %0d want 1", busy); end
      end
    end
    total++; if (busy !== 1'b0 || found !== 1'b0)
      begin bad++; $display("FAIL noscan_idle got busy=%0d found=%0d want 0/0", busy, found); end
    w0 = wr_count;
    key = 3'b100;
    repeat (10) @(negedge test_clk);
    key = 3'b000;
    total++; if (wr_count - w0 != 0 || busy !== 1'b0)
      begin bad++; $display("FAIL nofound_key got wr=%0d busy=%0d want 0/0", wr_count - w0, busy); end
    poke(149, 1);
    @(negedge test_clk);  rescan = 1'b1;
    @(negedge test_clk);  rescan = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rescan_busy got %0d want 1", busy); end
    repeat (160) @(negedge test_clk);
    total++; if (found !== 1'b1 || pos_row !== 4'd9 || pos_col !== 4'd14)
      begin bad++; $display("FAIL rescan_pos got f=%0d (%0d,%0d) want 1 (9,14)", found, pos_row, pos_col); end
    @(negedge test_clk);  rescan = 1'b1;  key = 3'b011;
    @(negedge test_clk);  rescan = 1'b0;  key = 3'b000;
    total++; if (busy !== 1'b1 || found !== 1'b0 || we !== 1'b0)
      begin bad++; $display("FAIL rescan_wins got busy=%0d found=%0d we=%0d want 1/0/0", busy, found, we); end
    repeat (160) @(negedge test_clk);
    total++; if (wr_count - w0 != 0 || found !== 1'b1 || pos_col !== 4'd14)
      begin bad++; $display("FAIL rescan_wins_after got wr=%0d found=%0d col=%0d want 0/1/14", wr_count - w0, found, pos_col); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_move_dig();
    test_edge_block();
    test_tile_block();
    test_back_to_back();
    test_rescan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
